// File: rtl/fft_frame_loader.sv
// rtl/fft_frame_loader.sv - streams complex samples into FFT working RAM port A, optionally bit-reversed, and hands full frames to the core
module fft_frame_loader #(
    parameter int ADDR_W   = 9,
    parameter int SAMPLE_W = 16,
    parameter int BITREV   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [SAMPLE_W-1:0]   s_re,
    input  logic [SAMPLE_W-1:0]   s_im,
    input  logic                  abort,
    input  logic                  fft_ack,
    output logic                  frame_valid,
    output logic                  ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [2*SAMPLE_W-1:0] ram_din,
    output logic [ADDR_W-1:0]     sample_idx,
    output logic [15:0]           frames_done
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] IDX_LAST = '1;

    state_t            state;
    state_t            state_next;
    logic              xfer;
    logic              take;
    logic [ADDR_W-1:0] wr_addr;

    function automatic logic [ADDR_W-1:0] bit_reverse(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        for (int i = 0; i < ADDR_W; i++) begin
            r[i] = a[ADDR_W-1-i];
        end
        return r;
    endfunction

    assign xfer    = s_valid && s_ready;
    // abort wins over a same-cycle transfer: the sample is dropped
    assign take    = xfer && !abort;
    assign wr_addr = (BITREV != 0) ? bit_reverse(sample_idx) : sample_idx;

    always_comb begin
        state_next  = state;
        s_ready     = 1'b0;
        frame_valid = 1'b0;
        case (state)
            ST_LOAD: begin
                s_ready = 1'b1;
                if (xfer && sample_idx == IDX_LAST) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                frame_valid = 1'b1;
                if (fft_ack) begin
                    state_next = ST_LOAD;
                end
            end
            default: begin
                state_next = ST_LOAD;
            end
        endcase
        if (abort) begin
            state_next = ST_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_LOAD;
            sample_idx  <= '0;
            frames_done <= '0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_din     <= '0;
        end else begin
            state  <= state_next;
            ram_we <= take;
            if (take) begin
                ram_addr   <= wr_addr;
                ram_din    <= {s_re, s_im};
                sample_idx <= sample_idx + ADDR_W'(1);
            end
            if (abort) begin
                sample_idx <= '0;
            end
            // count only a completed handoff, so an abort during FLUSH is not counted
            if (state == ST_FLUSH && state_next == ST_HOLD) begin
                frames_done <= frames_done + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_loader.sv
// tb/tb_fft_frame_loader.sv - randomized self-checking bench for fft_frame_loader (bit-reversed and natural-order instances)
module tb_fft_frame_loader;

    localparam int AW = 3;
    localparam int N  = 8;
    localparam int SW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          s_valid;
    logic [SW-1:0] s_re;
    logic [SW-1:0] s_im;
    logic          abort;
    logic          fft_ack;

    // index 1: BITREV=1 instance, index 0: natural-order instance
    logic [1:0]           s_ready;
    logic [1:0]           frame_valid;
    logic [1:0]           ram_we;
    logic [1:0][AW-1:0]   ram_addr;
    logic [1:0][2*SW-1:0] ram_din;
    logic [1:0][AW-1:0]   sample_idx;
    logic [1:0][15:0]     frames_done;

    fft_frame_loader #(.ADDR_W(AW), .SAMPLE_W(SW), .BITREV(1)) u_rev (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready[1]),
        .s_re(s_re), .s_im(s_im), .abort(abort), .fft_ack(fft_ack),
        .frame_valid(frame_valid[1]), .ram_we(ram_we[1]), .ram_addr(ram_addr[1]),
        .ram_din(ram_din[1]), .sample_idx(sample_idx[1]), .frames_done(frames_done[1])
    );

    fft_frame_loader #(.ADDR_W(AW), .SAMPLE_W(SW), .BITREV(0)) u_nat (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready[0]),
        .s_re(s_re), .s_im(s_im), .abort(abort), .fft_ack(fft_ack),
        .frame_valid(frame_valid[0]), .ram_we(ram_we[0]), .ram_addr(ram_addr[0]),
        .ram_din(ram_din[0]), .sample_idx(sample_idx[0]), .frames_done(frames_done[0])
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // RAM model: captures port A writes mid-cycle
    logic [31:0] mem [2][N];
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ram_we[d] === 1'b1) mem[d][ram_addr[d]] = ram_din[d];
        end
    end

    // behavioural model: phase 0 loading, 1 last write in flight, 2 frame held
    int          rev_tab [N] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int          m_idx;
    int          m_phase;
    logic [15:0] m_frames;
    logic        m_we;
    logic [1:0][AW-1:0] m_addr;
    logic [31:0] m_din;
    logic [31:0] m_frame [N];

    task automatic tick();
        if (!rst_n) begin
            m_idx = 0; m_phase = 0; m_frames = '0; m_we = 1'b0; m_addr = '0; m_din = '0;
        end else if (abort) begin
            m_idx = 0; m_phase = 0; m_we = 1'b0;
        end else begin
            m_we = 1'b0;
            if (m_phase == 0 && s_valid) begin
                m_we      = 1'b1;
                m_din     = {s_re, s_im};
                m_addr[1] = AW'(rev_tab[m_idx]);
                m_addr[0] = AW'(m_idx);
                m_frame[m_idx] = m_din;
                if (m_idx == N - 1) m_phase = 1;
                m_idx = (m_idx + 1) % N;
            end else if (m_phase == 1) begin
                m_phase = 2;
                m_frames = m_frames + 16'd1;
            end else if (m_phase == 2 && fft_ack) begin
                m_phase = 0;
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("s_ready[%0d]", d), 32'(s_ready[d]), 32'(m_phase == 0));
            check($sformatf("frame_valid[%0d]", d), 32'(frame_valid[d]), 32'(m_phase == 2));
            check($sformatf("ram_we[%0d]", d), 32'(ram_we[d]), 32'(m_we));
            check($sformatf("ram_addr[%0d]", d), 32'(ram_addr[d]), 32'(m_addr[d]));
            check($sformatf("ram_din[%0d]", d), ram_din[d], m_din);
            check($sformatf("sample_idx[%0d]", d), 32'(sample_idx[d]), 32'(m_idx));
            check($sformatf("frames_done[%0d]", d), 32'(frames_done[d]), 32'(m_frames));
        end
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_ack();
        fft_ack = 1'b1;
        tick();
        fft_ack = 1'b0;
    endtask

    task automatic send(input logic [31:0] v);
        s_valid = 1'b1;
        {s_re, s_im} = v;
        tick();
    endtask

    task automatic check_ram();
        for (int i = 0; i < N; i++) begin
            check($sformatf("ram_rev[%0d]", rev_tab[i]), mem[1][rev_tab[i]], m_frame[i]);
            check($sformatf("ram_nat[%0d]", i), mem[0][i], m_frame[i]);
        end
    endtask

    task automatic run_frame(input int gap_pct, input bit ramp);
        for (int i = 0; i < N; i++) begin
            while (int'($urandom_range(99)) < gap_pct) idle(1);
            if (ramp) send({16'(i), 16'(-i)});
            else send($urandom);
        end
        idle(2);
        check_ram();
    endtask

    int fd0;

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_re = '0; s_im = '0; abort = 1'b0; fft_ack = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // ramp frame on both instances; address order comes from rev_tab / natural index
        run_frame(0, 1'b1);
        check("t1_frames_done", 32'(frames_done[1]), 32'd1);
        check("t1_re_msb", 32'(mem[1][6][31:16]), 32'd3);

        // sample offered while frame is held is neither accepted nor written
        for (int i = 0; i < 5; i++) send($urandom);
        s_valid = 1'b0;
        do_ack();
        run_frame(0, 1'b0);
        do_ack();

        // random gaps and ack latency over three frames
        fd0 = int'(frames_done[1]);
        for (int f = 0; f < 3; f++) begin
            run_frame(50, 1'b0);
            idle(int'($urandom_range(3)));
            do_ack();
        end
        check("t4_frames_done", 32'(frames_done[1]), 32'(fd0 + 3));

        // abort after five samples, then a normal frame
        for (int i = 0; i < 5; i++) send($urandom);
        s_valid = 1'b0; abort = 1'b1; tick(); abort = 1'b0;
        check("t5_idx_after_abort", 32'(sample_idx[1]), 32'd0);
        run_frame(0, 1'b0);
        do_ack();

        // abort with simultaneous transfer, then abort during FLUSH
        for (int i = 0; i < 3; i++) send($urandom);
        abort = 1'b1; send(32'hDEADBEEF); abort = 1'b0;
        for (int i = 0; i < N; i++) send($urandom);
        s_valid = 1'b0; abort = 1'b1; tick(); abort = 1'b0;
        idle(2);
        run_frame(25, 1'b0);

        // abort and ack together while held
        abort = 1'b1; fft_ack = 1'b1; tick(); abort = 1'b0; fft_ack = 1'b0;

        // reset mid-frame and while held
        for (int i = 0; i < 3; i++) send($urandom);
        s_valid = 1'b0; rst_n = 1'b0; tick(); rst_n = 1'b1;
        run_frame(0, 1'b0);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        idle(1);

        // handoff counter wrap
        force u_rev.frames_done = 16'hFFFF;
        force u_nat.frames_done = 16'hFFFF;
        #1;
        release u_rev.frames_done;
        release u_nat.frames_done;
        m_frames = 16'hFFFF;
        run_frame(0, 1'b0);
        check("t6_wrap", 32'(frames_done[0]), 32'h0);
        do_ack();
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
